// File: rtl/ascon_perm_iter.sv
// ascon_perm_iter: Ascon p^a/p^b round controller and 320-bit state register; ASCON_PERM_HOLD_EN adds hold_i to freeze RUN
module ascon_perm_iter #(
  parameter int PB_ROUNDS = 6
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
`ifdef ASCON_PERM_HOLD_EN
  input  logic             hold_i,
`endif
  input  logic [4:0][63:0] state_i,
  input  logic [4:0][63:0] round_state_i,
  output logic [4:0][63:0] state_o,
  output logic [3:0]       round_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] PB_START = 4'(12 - PB_ROUNDS);
  if (PB_ROUNDS < 1 || PB_ROUNDS > 12) begin : g_bad_pb_rounds
    $error("ascon_perm_iter: PB_ROUNDS must be in 1..12");
  end
  logic [1:0]       fsm_q, fsm_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [4:0][63:0] st_q, st_d;
  logic             adv;
`ifdef ASCON_PERM_HOLD_EN
  assign adv = ~hold_i;
`else
  assign adv = 1'b1;
`endif
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    if (fsm_q == RUN) begin
      if (adv) begin
        st_d  = round_state_i;
        rnd_d = (rnd_q == 4'd11) ? rnd_q : rnd_q + 4'd1;
        fsm_d = (rnd_q == 4'd11) ? DONE : RUN;
      end
    end else if (start_i) begin
      st_d  = state_i;
      rnd_d = mode_i ? PB_START : 4'd0;
      fsm_d = RUN;
    end else begin
      fsm_d = IDLE;
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end
  assign state_o = st_q;
  assign round_o = rnd_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);
endmodule

// File: tb/tb_ascon_perm_iter.sv
// tb_ascon_perm_iter: scoreboard bench for ascon_perm_iter with stub and full Ascon round chains
module tb_ascon_perm_iter;
  typedef logic [4:0][63:0] st_t;
  localparam int PB = 6;
  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i  = 1'b0;
`ifdef ASCON_PERM_HOLD_EN
  logic       hold_i  = 1'b0;
`endif
  st_t        state_i = '0;
  st_t        round_state_i;
  st_t        state_o;
  logic [3:0] round_o;
  logic       busy_o, done_o;
  int         errors = 0;
  int         checks = 0;
  bit         full = 1'b0;
  st_t        exp_q[$];
  int         exp_n[$];
  ascon_perm_iter #(.PB_ROUNDS(PB)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
`ifdef ASCON_PERM_HOLD_EN
    .hold_i(hold_i),
`endif
    .state_i(state_i), .round_state_i(round_state_i), .state_o(state_o),
    .round_o(round_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clock_i = ~clock_i;
  function automatic logic [63:0] rc(logic [3:0] r);
    return {56'd0, 4'hf - r, r};
  endfunction
  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic st_t stub(st_t s, logic [3:0] r);
    s[2] = s[2] ^ rc(r);
    return s;
  endfunction
  function automatic st_t ascon_round(st_t s, logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2] ^ rc(r); x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    s[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    s[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    s[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    s[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    s[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return s;
  endfunction
  always_comb round_state_i = full ? ascon_round(state_o, round_o) : stub(state_o, round_o);
  task automatic chk(string tag, logic [319:0] obs, logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic st_t rnd_state();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction
  task automatic start_run(bit m, st_t s);
    int n;
    st_t e;
    n = m ? PB : 12;
    e = s;
    for (int r = 12 - n; r < 12; r++) e = full ? ascon_round(e, 4'(r)) : stub(e, 4'(r));
    exp_q.push_back(e);
    exp_n.push_back(n);
    start_i = 1'b1;
    mode_i  = m;
    state_i = s;
  endtask
  task automatic wait_done(string tag, bit keep);
    int n, lat;
    st_t e;
    n = exp_n[0];
    lat = 1;
    @(negedge clock_i);
    if (!keep) begin
      start_i = 1'b0;
      mode_i  = 1'($urandom);
      state_i = rnd_state();
    end
    while (!done_o && lat < 40) begin
      chk({tag, " busy"}, busy_o, 1);
      chk({tag, " round"}, round_o, 320'(12 - n + lat - 1));
      @(negedge clock_i);
      lat++;
    end
    chk({tag, " latency"}, 320'(lat), 320'(n + 1));
    chk({tag, " busy_in_done"}, busy_o, 0);
    e = exp_q.pop_front();
    void'(exp_n.pop_front());
    for (int i = 0; i < 5; i++) chk($sformatf("%s word%0d", tag, i), state_o[i], e[i]);
  endtask
  initial begin
    st_t s;
    bit seen;
    repeat (2) @(negedge clock_i);
    chk("reset state", state_o, 0);
    chk("reset round", round_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("idle hold", {busy_o, done_o, round_o}, 0);
    start_run(1'b0, '0);
    wait_done("stub_pa", 1'b0);
    chk("stub_pa zero", state_o, 0);
    @(negedge clock_i);
    chk("stub_pa single pulse", done_o, 0);
    chk("stub_pa state hold", state_o, 0);
    start_run(1'b1, '0);
    wait_done("stub_pb", 1'b0);
    chk("stub_pb s2", state_o[2][7:0], 8'h11);
    chk("stub_pb others", {state_o[0], state_o[1], state_o[2][63:8], state_o[3], state_o[4]}, 0);
    @(negedge clock_i);
    full = 1'b1;
    s = '0;
    s[0] = 64'h80400c0600000000;
    start_run(1'b0, s);
    wait_done("ascon_init_pa", 1'b0);
    @(negedge clock_i);
    start_run(1'b1, rnd_state());
    wait_done("full_pb", 1'b0);
    @(negedge clock_i);
    full = 1'b0;
    start_i = 1'b1; mode_i = 1'b0; state_i = rnd_state();
    repeat (5) @(negedge clock_i);
    start_i = 1'b0;
    chk("abort pre round", round_o, 4);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("abort state", state_o, 0);
    chk("abort round", round_o, 0);
    chk("abort busy", busy_o, 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock_i);
      seen |= done_o | busy_o;
    end
    chk("abort no done", seen, 0);
    start_run(1'b0, rnd_state());
    wait_done("after_abort", 1'b0);
    @(negedge clock_i);
    full = 1'b1;
    s = rnd_state();
    start_run(1'b0, s);
    wait_done("b2b_1", 1'b1);
    start_run(1'b0, state_o);
    wait_done("b2b_2", 1'b0);
    @(negedge clock_i);
    chk("b2b idle", {busy_o, done_o}, 0);
`ifdef ASCON_PERM_HOLD_EN
    start_run(1'b0, s);
    @(negedge clock_i);
    start_i = 1'b0;
    for (int lat = 1; lat <= 15; lat++) begin
      chk("hold busy", busy_o, 1);
      chk("hold round", round_o, (lat <= 5) ? lat - 1 : (lat <= 8) ? 4 : lat - 4);
      hold_i = (lat >= 5 && lat <= 7);
      @(negedge clock_i);
    end
    hold_i = 1'b0;
    chk("hold done at 16", done_o, 1);
    s = exp_q.pop_front();
    void'(exp_n.pop_front());
    chk("hold state", state_o, s);
    @(negedge clock_i);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
